uart_rx_ctrl: RTL and testbench

- UART receive stage sitting directly upstream of the 8-bit single-port, synchronous-read FIFO RAM (uart_fifo).
- Deserialises 8N1 serial input and pushes each good byte into the RAM.
- Owns the FIFO read/write pointers and occupancy.
- Arbitrates the RAM's single address port between push and a consumer-side pop handshake; returns popped bytes one cycle after acceptance.

---
 rtl/uart_rx_ctrl.sv | 142 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - 8N1 UART receiver feeding a single-port FIFO RAM.
// Owns FIFO pointers/occupancy and arbitrates the RAM port between push and pop.
module uart_rx_ctrl #(
  parameter int ADDR_WIDTH   = 9,
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 104
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  pop,
  output logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_rd,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state;
  logic                  rx_meta;
  logic                  rxs;
  logic [CW-1:0]         cnt;
  logic [2:0]            idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  pending;
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [DATA_WIDTH-1:0] held;
  logic                  wslot;
  logic                  drop;
  logic                  accept;

  assign empty     = (count == '0);
  assign full      = (count == DEPTH);
  assign wslot     = pending & ~full;
  assign drop      = pending & full;
  assign pop_ready = ~empty & ~wslot;
  assign accept    = pop & pop_ready;
  assign mem_wen   = wslot;
  assign mem_addr  = wslot ? wptr : rptr;
  assign mem_wd    = wslot ? shreg : '0;
  assign overrun   = drop;
  // RAM read data lands the cycle after acceptance; held keeps it visible afterwards.
  assign out_data  = out_valid ? mem_rd : held;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      pending   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (wslot || drop) pending <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            idx <= '0;
            state <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rxs, shreg[DATA_WIDTH-1:1]};
            if (idx == 3'(DATA_WIDTH - 1)) state <= STOP;
            else                           idx   <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            if (rxs) pending   <= 1'b1;
            else     frame_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      held      <= '0;
    end else begin
      out_valid <= accept;
      if (out_valid) held <= mem_rd;
      if (wslot) begin
        wptr  <= wptr + 1'b1;
        count <= count + 1'b1;
      end else if (accept) begin
        rptr  <= rptr + 1'b1;
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed bench for uart_rx_ctrl with a behavioural RAM.
module tb_uart_rx_ctrl;
  localparam int AW  = 2;
  localparam int DW  = 8;
  localparam int CPB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic          pop = 1'b0;
  logic          pop_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic          mem_wen;
  logic [DW-1:0] mem_rd;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          frame_err;
  logic          overrun;

  uart_rx_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .pop(pop), .pop_ready(pop_ready),
    .out_data(out_data), .out_valid(out_valid), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_wen(mem_wen), .mem_rd(mem_rd), .count(count),
    .empty(empty), .full(full), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_wen) ram[mem_addr] <= mem_wd;
    mem_rd <= ram[mem_addr];
  end

  int wr_n = 0, ferr_n = 0, ovr_n = 0, ov_n = 0;
  logic [AW-1:0] wr_addr_last;
  logic [DW-1:0] wr_data_last;
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wen) begin
        wr_n++;
        wr_addr_last = mem_addr;
        wr_data_last = mem_wd;
      end
      if (frame_err) ferr_n++;
      if (overrun)   ovr_n++;
      if (out_valid) ov_n++;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_data"},  32'(out_data), 0);
    chk({tag, "_mem_wen"},   32'(mem_wen), 0);
    chk({tag, "_mem_addr"},  32'(mem_addr), 0);
    chk({tag, "_mem_wd"},    32'(mem_wd), 0);
    chk({tag, "_frame_err"}, 32'(frame_err), 0);
    chk({tag, "_overrun"},   32'(overrun), 0);
    chk({tag, "_pop_ready"}, 32'(pop_ready), 0);
    chk({tag, "_count"},     32'(count), 0);
    chk({tag, "_empty"},     32'(empty), 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1; rx = 1'b1; pop = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(posedge clk); #1 rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk); #1 rx = b[i];
    end
    repeat (CPB) @(posedge clk); #1 rx = stop_bit;
    repeat (CPB) @(posedge clk); #1 rx = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic pop_one(input string tag, input logic [7:0] exp);
    @(posedge clk); #1 pop = 1'b1;
    @(negedge clk);
    chk({tag, "_pop_ready"}, 32'(pop_ready), 1);
    @(posedge clk); #1 pop = 1'b0;
    @(negedge clk);
    chk({tag, "_out_valid"}, 32'(out_valid), 1);
    chk({tag, "_out_data"}, 32'(out_data), 32'(exp));
    @(negedge clk);
    chk({tag, "_out_hold"}, 32'(out_data), 32'(exp));
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         exp_writes;
    logic [1:0] exp_addr;
    int         exp_ferr;
    int         exp_ovr;
    int         exp_count;
    logic       exp_full;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int w0, f0, o0, v0;
    logic found;

    vecs[0] = '{8'h01, 1'b1, 1, 2'd0, 0, 0, 1, 1'b0};
    vecs[1] = '{8'h02, 1'b1, 1, 2'd1, 0, 0, 2, 1'b0};
    vecs[2] = '{8'h03, 1'b1, 1, 2'd2, 0, 0, 3, 1'b0};
    vecs[3] = '{8'h04, 1'b1, 1, 2'd3, 0, 0, 4, 1'b1};
    vecs[4] = '{8'h05, 1'b1, 0, 2'd0, 0, 1, 4, 1'b1};
    vecs[5] = '{8'h66, 1'b0, 0, 2'd0, 1, 0, 4, 1'b1};

    repeat (2) @(negedge clk);
    check_reset("rst");
    @(posedge clk); #1 rst = 1'b0;

    // single byte
    w0 = wr_n;
    send_byte(8'hA5, 1'b1);
    @(negedge clk);
    chk("single_writes", 32'(wr_n - w0), 1);
    chk("single_addr", 32'(wr_addr_last), 0);
    chk("single_data", 32'(wr_data_last), 32'hA5);
    chk("single_count", 32'(count), 1);
    pop_one("single_pop", 8'hA5);
    chk("single_count_after", 32'(count), 0);
    chk("single_empty_after", 32'(empty), 1);

    // fill / overrun / framing, table driven
    do_reset();
    for (int i = 0; i < 6; i++) begin
      w0 = wr_n; f0 = ferr_n; o0 = ovr_n;
      send_byte(vecs[i].data, vecs[i].stop_bit);
      @(negedge clk);
      chk($sformatf("vec%0d_writes", i), 32'(wr_n - w0), 32'(vecs[i].exp_writes));
      if (vecs[i].exp_writes == 1) begin
        chk($sformatf("vec%0d_addr", i), 32'(wr_addr_last), 32'(vecs[i].exp_addr));
        chk($sformatf("vec%0d_data", i), 32'(wr_data_last), 32'(vecs[i].data));
      end
      chk($sformatf("vec%0d_frame_err", i), 32'(ferr_n - f0), 32'(vecs[i].exp_ferr));
      chk($sformatf("vec%0d_overrun", i), 32'(ovr_n - o0), 32'(vecs[i].exp_ovr));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
    end
    for (int i = 0; i < 4; i++) pop_one($sformatf("drain%0d", i), 8'(i + 1));
    chk("drain_count", 32'(count), 0);
    chk("drain_empty", 32'(empty), 1);
    chk("drain_rptr_wrap", 32'(mem_addr), 0);

    // short low glitch on rx
    w0 = wr_n; f0 = ferr_n; o0 = ovr_n;
    @(posedge clk); #1 rx = 1'b0;
    repeat (2) @(posedge clk); #1 rx = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("glitch_writes", 32'(wr_n - w0), 0);
    chk("glitch_flags", 32'((ferr_n - f0) + (ovr_n - o0)), 0);
    chk("glitch_count", 32'(count), 0);

    // pop collides with a write slot
    send_byte(8'h11, 1'b1);
    @(negedge clk);
    chk("coll_pre_count", 32'(count), 1);
    fork
      send_byte(8'h22, 1'b1);
      begin
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
          @(negedge clk);
          if (mem_wen) found = 1'b1;
        end
        chk("coll_write_seen", 32'(found), 1);
        if (found) begin
          pop = 1'b1;
          #1;
          chk("coll_pop_ready", 32'(pop_ready), 0);
          chk("coll_mem_wen", 32'(mem_wen), 1);
          chk("coll_mem_addr", 32'(mem_addr), 1);
          @(posedge clk); #1;
          @(negedge clk);
          chk("coll_retry_ready", 32'(pop_ready), 1);
          chk("coll_mid_count", 32'(count), 2);
          @(posedge clk); #1 pop = 1'b0;
          @(negedge clk);
          chk("coll_out_valid", 32'(out_valid), 1);
          chk("coll_out_data", 32'(out_data), 32'h11);
        end
        pop = 1'b0;
      end
    join
    pop_one("coll_second", 8'h22);

    // pop while empty
    v0 = ov_n;
    chk("empty_pre_addr", 32'(mem_addr), 2);
    @(posedge clk); #1 pop = 1'b1;
    @(negedge clk);
    chk("empty_pop_ready", 32'(pop_ready), 0);
    @(posedge clk); #1 pop = 1'b0;
    repeat (2) @(negedge clk);
    chk("empty_no_valid", 32'(ov_n - v0), 0);
    chk("empty_rptr_same", 32'(mem_addr), 2);

    // reset in the middle of a frame
    @(posedge clk); #1 rx = 1'b0;
    for (int i = 0; i < 5; i++) begin
      repeat (CPB) @(posedge clk); #1 rx = i[0] ? 1'b1 : 1'b0;
    end
    repeat (2) @(posedge clk); #1 rst = 1'b1; rx = 1'b1;
    @(negedge clk);
    check_reset("midrst");
    @(posedge clk); #1 rst = 1'b0;
    w0 = wr_n; f0 = ferr_n;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("midrst_no_write", 32'(wr_n - w0), 0);
    chk("midrst_no_ferr", 32'(ferr_n - f0), 0);
    w0 = wr_n;
    send_byte(8'h3C, 1'b1);
    @(negedge clk);
    chk("after_rst_writes", 32'(wr_n - w0), 1);
    chk("after_rst_addr", 32'(wr_addr_last), 0);
    chk("after_rst_data", 32'(wr_data_last), 32'h3C);
    pop_one("after_rst_pop", 8'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
